// File: rtl/sram_array_ctrl_if.sv
// Single-port request/response bus of the SRAM array controller.
// The requester takes the master side; the array takes the slave side.
interface sram_array_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WIDTH-1:0]  req_wdata;
    logic [WIDTH-1:0]  req_wmask;
    logic [WIDTH-1:0]  rdata;
    logic              rvalid;
    logic              err;
    logic              init_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rdata, rvalid, err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rdata, rvalid, err, init_done
    );
endinterface

// File: rtl/sram_array_ctrl.sv
// Synchronous SRAM array model: DEPTH x WIDTH words, per-bit write mask,
// out-of-range detection, optional post-reset clear sweep, fixed 3-cycle access.
module sram_array_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH),
    parameter bit INIT_CLEAR = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    sram_array_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_PRE, ST_ACC} state_t;

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  wmask_q;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = (mem[addr_q] & ~wmask_q) | (wdata_q & wmask_q);
        if (state == ST_INIT) begin
            mem_we    = rst_n;
            mem_addr  = cnt;
            mem_wdata = '0;
        end else if (state == ST_ACC && we_q && in_range) begin
            // rst_n gating keeps an asserted reset from landing a write.
            mem_we = rst_n;
        end
    end

    // NOTE: the storage array has no reset; only the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT_CLEAR ? ST_INIT : ST_IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            bus.req_ready <= 1'b0;
            bus.rdata     <= '0;
            bus.rvalid    <= 1'b0;
            bus.err       <= 1'b0;
            bus.init_done <= 1'b0;
        end else begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        cnt           <= '0;
                        state         <= ST_IDLE;
                        bus.init_done <= 1'b1;
                        bus.req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    bus.init_done <= 1'b1;
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        we_q          <= bus.req_we;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        wmask_q       <= bus.req_wmask;
                        bus.req_ready <= 1'b0;
                        state         <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    state <= ST_ACC;
                end
                ST_ACC: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    if (!in_range) bus.err <= 1'b1;
                    if (!we_q) begin
                        bus.rvalid <= 1'b1;
                        bus.rdata  <= in_range ? mem[addr_q] : '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
